// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: next-PC select codes
// and sequencer FSM state encodings.
package pc_sequencer_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_JMP = 2'b01;
    localparam logic [1:0] PCSRC_BR  = 2'b10;
    localparam logic [1:0] PCSRC_RET = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10,
        ST_HALT  = 2'b11
    } pcs_state_e;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address stack: circular storage with a write pointer and a
// saturating valid count. A push when full overwrites the oldest entry.
// Ports:
//   clk, rst_n   clock, async active-low reset (clears count/pointer)
//   push_i       write data_i at the top, count saturates at DEPTH
//   pop_i        drop the top entry (ignored when empty)
//   data_i       address to push
//   top_o        most recently pushed valid entry
//   cnt_o        number of valid entries (0..DEPTH)
//   full_o       cnt_o == DEPTH
//   empty_o      cnt_o == 0
module pc_sequencer_ras_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  top_o,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    // ptr_q is the next free slot; the top sits one below it (mod DEPTH).
    assign top_o   = mem_q[ptr_q - AW'(1)];

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i) begin
            ptr_d = ptr_q + AW'(1);
            if (!full_o) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_q - AW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents are meaningless once the count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: owns the PC register, a BOOT/RUN/FLUSH/HALT FSM,
// and a return-address stack for call/return redirects.
// Optional feature macro: RAS_TRAP_EN (trap + HALT on RAS overflow or
// underflow; without it the stack wraps and empty returns go to RESET_PC).
// Ports:
//   clk, rst_n       clock, async active-low reset
//   stall_i          freeze PC, FSM and RAS (not in HALT)
//   pc_src_i         00 seq, 01 jump, 10 branch taken, 11 return
//   is_call_i        with jump: push link_pc_i
//   jump_target_i    jump target
//   br_target_i      taken-branch target
//   link_pc_i        return address pushed by a call
//   pc_o             fetch address
//   fetch_valid_o    instruction at pc_o is issued
//   flush_o          kill the IF/ID instruction
//   ras_cnt_o        valid RAS entries
//   trap_o           one-cycle RAS fault pulse
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter int              RAS_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(16'hFFF0),
    parameter int              CW        = $clog2(RAS_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic [1:0]      pc_src_i,
    input  logic            is_call_i,
    input  logic [PC_W-1:0] jump_target_i,
    input  logic [PC_W-1:0] br_target_i,
    input  logic [PC_W-1:0] link_pc_i,
    output logic [PC_W-1:0] pc_o,
    output logic            fetch_valid_o,
    output logic            flush_o,
    output logic [CW-1:0]   ras_cnt_o,
    output logic            trap_o
);

    pcs_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fv_q, fv_d;
    logic            flush_q, flush_d;

    logic            act;
    logic            push_req, pop_req;
    logic            ras_push, ras_pop;
    logic            ras_full, ras_empty;
    logic [PC_W-1:0] ras_top;
    logic [PC_W-1:0] ret_tgt;
    logic            fault;

    // A decision is taken only in RUN on a non-stalled cycle.
    assign act      = (state_q == ST_RUN) && !stall_i;
    assign push_req = act && (pc_src_i == PCSRC_JMP) && is_call_i;
    assign pop_req  = act && (pc_src_i == PCSRC_RET);
    assign ret_tgt  = ras_empty ? RESET_PC : ras_top;

`ifdef RAS_TRAP_EN
    logic trap_q;

    assign fault    = (push_req && ras_full) || (pop_req && ras_empty);
    assign ras_push = push_req && !ras_full;
    assign ras_pop  = pop_req && !ras_empty;
    assign trap_o   = trap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= fault;
        end
    end
`else
    logic unused_full;

    assign unused_full = ras_full;
    assign fault       = 1'b0;
    assign ras_push    = push_req;
    assign ras_pop     = pop_req && !ras_empty;
    assign trap_o      = 1'b0;
`endif

    pc_sequencer_ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (link_pc_i),
        .top_o   (ras_top),
        .cnt_o   (ras_cnt_o),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (state_q != ST_HALT && !stall_i) begin
            unique case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (fault) begin
                        pc_d    = TRAP_VEC;
                        state_d = ST_HALT;
                    end else begin
                        unique case (pc_src_i)
                            PCSRC_SEQ: pc_d = pc_q + PC_W'(1);
                            PCSRC_JMP: pc_d = jump_target_i;
                            PCSRC_BR:  pc_d = br_target_i;
                            PCSRC_RET: pc_d = ret_tgt;
                        endcase
                        if (pc_src_i != PCSRC_SEQ) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_RUN;
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
            endcase
        end
        // Outputs are registered copies of what the next state implies.
        fv_d    = (state_d == ST_RUN);
        flush_d = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            fv_q    <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fv_q    <= fv_d;
            flush_q <= flush_d;
        end
    end

    assign pc_o          = pc_q;
    assign fetch_valid_o = fv_q;
    assign flush_o       = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized traffic against a queue-based reference model.
module tb_pc_sequencer;

    localparam int PC_W = 16;
    localparam int D    = 8;
    localparam int CW   = $clog2(D) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stall_i = 1'b0;
    logic [1:0]      pc_src_i = 2'b00;
    logic            is_call_i = 1'b0;
    logic [PC_W-1:0] jump_target_i = '0;
    logic [PC_W-1:0] br_target_i = '0;
    logic [PC_W-1:0] link_pc_i = '0;
    logic [PC_W-1:0] pc_o;
    logic            fetch_valid_o;
    logic            flush_o;
    logic [CW-1:0]   ras_cnt_o;
    logic            trap_o;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .pc_src_i      (pc_src_i),
        .is_call_i     (is_call_i),
        .jump_target_i (jump_target_i),
        .br_target_i   (br_target_i),
        .link_pc_i     (link_pc_i),
        .pc_o          (pc_o),
        .fetch_valid_o (fetch_valid_o),
        .flush_o       (flush_o),
        .ras_cnt_o     (ras_cnt_o),
        .trap_o        (trap_o)
    );

    always #5 clk = ~clk;

    // Reference model: plain PC value, a few phase flags, a queue as the stack.
    logic [PC_W-1:0] m_pc;
    bit              m_boot, m_bubble, m_halt, m_trap;
    logic [PC_W-1:0] m_ras[$];

    task automatic model_reset();
        m_pc = '0; m_boot = 1; m_bubble = 0; m_halt = 0; m_trap = 0;
        m_ras.delete();
    endtask

    task automatic model_step();
        bit fault = 0;
        m_trap = 0;
        if (m_halt || stall_i) return;
        if (m_boot) begin
            m_boot = 0;
        end else if (m_bubble) begin
            m_pc++;
            m_bubble = 0;
        end else begin
            case (pc_src_i)
                2'd0: m_pc++;
                2'd1: begin
                    if (is_call_i) begin
                        if (m_ras.size() == D) begin
`ifdef RAS_TRAP_EN
                            fault = 1;
`else
                            void'(m_ras.pop_front());
`endif
                        end
                        if (!fault) m_ras.push_back(link_pc_i);
                    end
                    if (!fault) begin m_pc = jump_target_i; m_bubble = 1; end
                end
                2'd2: begin m_pc = br_target_i; m_bubble = 1; end
                default: begin
                    if (m_ras.size() == 0) begin
`ifdef RAS_TRAP_EN
                        fault = 1;
`else
                        m_pc = '0;
`endif
                    end else begin
                        m_pc = m_ras.pop_back();
                    end
                    if (!fault) m_bubble = 1;
                end
            endcase
            if (fault) begin
                m_pc = 16'hFFF0; m_halt = 1; m_trap = 1;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".pc"}, 32'(pc_o), 32'(m_pc));
        chk({tag, ".fv"}, 32'(fetch_valid_o),
            32'(!(m_boot || m_bubble || m_halt)));
        chk({tag, ".flush"}, 32'(flush_o), 32'(m_bubble));
        chk({tag, ".cnt"}, 32'(ras_cnt_o), 32'(m_ras.size()));
        chk({tag, ".trap"}, 32'(trap_o), 32'(m_trap));
    endtask

    task automatic drive(logic [1:0] src, logic call, logic [PC_W-1:0] jt,
                         logic [PC_W-1:0] bt, logic [PC_W-1:0] lk, logic st);
        pc_src_i = src; is_call_i = call; jump_target_i = jt;
        br_target_i = bt; link_pc_i = lk; stall_i = st;
    endtask

    task automatic cyc(string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        drive(2'd0, 0, '0, '0, '0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        do_reset("rst");

        // 1: boot then sequential fetch 0,1,2,3
        for (int i = 0; i < 4; i++) cyc("t1");
        chk("t1.pc3", 32'(pc_o), 32'h3);

        // 2: reach pc=5, take a branch to 0x40
        cyc("t2a"); cyc("t2b");
        chk("t2.pc5", 32'(pc_o), 32'h5);
        drive(2'd2, 1, 16'h1234, 16'h0040, 16'h0077, 0);
        cyc("t2br");
        chk("t2.pc40", 32'(pc_o), 32'h40);
        chk("t2.nopush", 32'(ras_cnt_o), 32'h0);
        drive(2'd3, 0, '0, '0, '0, 0);
        cyc("t2fl");
        chk("t2.pc41", 32'(pc_o), 32'h41);

        // 3: call then return
        drive(2'd1, 1, 16'h0080, '0, 16'h0011, 0);
        cyc("t3call");
        chk("t3.cnt1", 32'(ras_cnt_o), 32'h1);
        drive(2'd0, 0, '0, '0, '0, 0);
        cyc("t3fl");
        drive(2'd3, 0, '0, '0, '0, 0);
        cyc("t3ret");
        chk("t3.pc11", 32'(pc_o), 32'h11);
        chk("t3.cnt0", 32'(ras_cnt_o), 32'h0);
        drive(2'd0, 0, '0, '0, '0, 0);
        cyc("t3fl2");

        // 4: stall for 3 cycles during FLUSH
        drive(2'd2, 0, '0, 16'h0100, '0, 0);
        cyc("t4br");
        drive(2'd1, 1, 16'h0999, '0, 16'h0555, 1);
        for (int i = 0; i < 3; i++) cyc("t4st");
        chk("t4.flush", 32'(flush_o), 32'h1);
        chk("t4.pc", 32'(pc_o), 32'h100);
        drive(2'd1, 1, 16'h0999, '0, 16'h0555, 0);
        cyc("t4rel");
        chk("t4.pc101", 32'(pc_o), 32'h101);
        drive(2'd0, 0, '0, '0, '0, 0);
        cyc("t4seq");

`ifndef RAS_TRAP_EN
        // 5: nine calls wrap the stack, eight returns give 9..2, then empty
        for (int i = 1; i <= 9; i++) begin
            drive(2'd1, 1, 16'(16'h0200 + i), '0, 16'(i), 0);
            cyc("t5call");
            drive(2'd0, 0, '0, '0, '0, 0);
            cyc("t5fl");
        end
        chk("t5.cnt8", 32'(ras_cnt_o), 32'h8);
        for (int i = 9; i >= 2; i--) begin
            drive(2'd3, 0, '0, '0, '0, 0);
            cyc("t5ret");
            chk("t5.link", 32'(pc_o), 32'(i));
            drive(2'd0, 0, '0, '0, '0, 0);
            cyc("t5fl2");
        end
        drive(2'd3, 0, '0, '0, '0, 0);
        cyc("t5empty");
        chk("t5.rstpc", 32'(pc_o), 32'h0);
        drive(2'd0, 0, '0, '0, '0, 0);
        cyc("t5fl3");
`else
        // 6: return with empty stack traps and halts until reset
        drive(2'd3, 0, '0, '0, '0, 0);
        cyc("t6ret");
        chk("t6.trap", 32'(trap_o), 32'h1);
        chk("t6.pc", 32'(pc_o), 32'hFFF0);
        drive(2'd2, 0, '0, 16'h0300, '0, 1);
        cyc("t6h1");
        drive(2'd2, 0, '0, 16'h0300, '0, 0);
        cyc("t6h2");
        chk("t6.fv", 32'(fetch_valid_o), 32'h0);
        chk("t6.hold", 32'(pc_o), 32'hFFF0);
        do_reset("t6rst");
        cyc("t6boot");
`endif

        // Randomized traffic with periodic asynchronous resets
        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 96) do_reset("rrst");
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) == 0));
            cyc("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
